display_scan_ctrl: RTL and testbench

//  Time-multiplexing scheduler for the 8-digit common-anode seven-segment display on Top_Level.

---
 rtl/disp_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 14 +
 rtl/display_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment scan controller: digit count,
// active-low segment patterns, scan-phase encoding and the leading-digit helper.
package disp_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // {a,b,c,d,e,f,g}, 0 = segment lit
  localparam logic [6:0] SEG7_TABLE [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Index of the most significant nonzero nibble; 0 when the whole word is zero.
  function automatic logic [2:0] top_nonzero(input logic [31:0] v);
    logic [2:0] k;
    k = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      k = (v[4*i +: 4] != 4'h0) ? 3'(i) : k;
    end
    return k;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low {a..g} pattern, purely combinational.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup into the shared pattern ROM
  always_comb begin
    o_seg = SEG7_TABLE[i_nibble];
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of an 8-digit common-anode display: each digit slot is a
// blanking phase then a drive phase, fed from a frame snapshot latched once per scan.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  input  logic        lz_suppress,
  output logic [7:0]  anode,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  scan_state_e   r_state;

  logic [31:0]   r_frm_value;
  logic [7:0]    r_frm_en;
  logic [7:0]    r_frm_dp;
  logic          r_frm_lz;

  logic [7:0]    r_anode;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_tick;

  logic          w_slot_end;
  logic          w_frame_start;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg;
  logic [2:0]    w_top;
  logic          w_suppressed;
  logic          w_lit;

  assign w_slot_end    = (r_cnt == SLOT_LAST);
  // First cycle of digit 0's blanking phase opens a new frame
  assign w_frame_start = (r_state == BLANK) && (r_cnt == {CW{1'b0}}) && (r_idx == 3'd0);

  assign w_nibble     = r_frm_value[{r_idx, 2'b00} +: 4];
  assign w_top        = top_nonzero(r_frm_value);
  assign w_suppressed = r_frm_lz && (r_idx > w_top);
  assign w_lit        = (r_state == DRIVE) && r_frm_en[r_idx] && !w_suppressed;

  seg7_decode u_seg7_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Slot counter and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CW{1'b0}};
      r_idx <= 3'd0;
    end else if (w_slot_end) begin
      r_cnt <= {CW{1'b0}};
      r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      r_idx <= r_idx;
    end
  end

  // Frame snapshot so a scan never mixes two different input words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frm_value <= 32'h0000_0000;
      r_frm_en    <= 8'h00;
      r_frm_dp    <= 8'h00;
      r_frm_lz    <= 1'b0;
    end else if (w_frame_start) begin
      r_frm_value <= value;
      r_frm_en    <= digit_en;
      r_frm_dp    <= dp_in;
      r_frm_lz    <= lz_suppress;
    end else begin
      r_frm_value <= r_frm_value;
      r_frm_en    <= r_frm_en;
      r_frm_dp    <= r_frm_dp;
      r_frm_lz    <= r_frm_lz;
    end
  end

  // Scan FSM with registered pin drivers; async reset darkens the pins at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= BLANK;
      r_anode      <= 8'hFF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      case (r_state)
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_state <= DRIVE;
          end else begin
            r_state <= BLANK;
          end
        end
        DRIVE: begin
          if (w_slot_end) begin
            r_state <= BLANK;
          end else begin
            r_state <= DRIVE;
          end
        end
        default: r_state <= BLANK;
      endcase

      r_frame_tick <= w_frame_start;

      if (w_lit) begin
        r_anode <= ~(8'h01 << r_idx);
        r_seg   <= w_seg;
        r_dp    <= ~r_frm_dp[r_idx];
      end else begin
        r_anode <= 8'hFF;
        r_seg   <= 7'h7F;
        r_dp    <= 1'b1;
      end
    end
  end

  assign anode      = r_anode;
  assign a          = r_seg[6];
  assign b          = r_seg[5];
  assign c          = r_seg[4];
  assign d          = r_seg[3];
  assign e          = r_seg[2];
  assign f          = r_seg[1];
  assign g          = r_seg[0];
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a short slot (10 cycles, 2 blank)
// against a cycle-count reference model of the scan schedule.
module tb_display_scan_ctrl;

  localparam int RD = 10;
  localparam int BC = 2;
  localparam int FR = RD * 8;
  localparam logic [17:0] DARK = {8'hFF, 7'h7F, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = 32'h0;
  logic [7:0]  digit_en = 8'h00;
  logic [7:0]  dp_in = 8'h00;
  logic        lz_suppress = 1'b0;
  logic [7:0]  anode;
  logic        a, b, c, d, e, f, g, dp, frame_tick;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .lz_suppress(lz_suppress), .anode(anode), .a(a), .b(b), .c(c), .d(d),
    .e(e), .f(f), .g(g), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          m_j = 0;
  logic [31:0] m_val = 32'h0;
  logic [7:0]  m_en = 8'h00;
  logic [7:0]  m_dp = 8'h00;
  logic        m_lz = 1'b0;
  logic [17:0] exp_o = 18'h0;
  logic [17:0] obs;
  logic [6:0]  dec_tab [16];

  assign obs = {anode, a, b, c, d, e, f, g, dp, frame_tick};

  // Model: cycle j after release sits in slot (j/RD)%8 at position j%RD; blank for the
  // first BC positions; inputs are snapshotted at every multiple of FR.
  task automatic step();
    int p, dg, k;
    logic [3:0] nib;
    bit lit;
    @(posedge clk);
    if (reset) begin
      exp_o = DARK;
    end else begin
      if (m_j % FR == 0) begin
        m_val = value; m_en = digit_en; m_dp = dp_in; m_lz = lz_suppress;
      end
      p  = m_j % RD;
      dg = (m_j / RD) % 8;
      k  = 0;
      for (int i = 0; i < 8; i++) if (((m_val >> (4 * i)) & 32'hF) != 32'h0) k = i;
      nib = 4'((m_val >> (4 * dg)) & 32'hF);
      lit = (p >= BC) && m_en[dg] && !(m_lz && dg > k);
      if (lit) exp_o = {~(8'd1 << dg), dec_tab[nib], ~m_dp[dg], 1'b0};
      else     exp_o = DARK;
      exp_o[0] = (m_j % FR == 0);
      m_j++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_j = 0; m_val = 32'h0; m_en = 8'h00; m_dp = 8'h00; m_lz = 1'b0;
  endtask

  task automatic align_frame();
    for (int i = 0; i < FR && (m_j % FR != 0); i++) step();
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (obs !== DARK) begin
        n_fail++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, DARK);
      end
    end
    value = 32'h0000_0012; digit_en = 8'hFF; dp_in = 8'h00; lz_suppress = 1'b1;
    reset = 1'b0;
    step();
    n_chk++;
    if (frame_tick !== 1'b1 || obs !== exp_o) begin
      n_fail++; $display("FAIL first_tick got=%h exp=%h", obs, exp_o);
    end
  endtask

  task automatic test_lz_basic();
    int n_fe, n_fd, n_other;
    n_fe = 0; n_fd = 0; n_other = 0;
    for (int i = 1; i < 2 * FR; i++) begin
      step();
      n_chk++;
      if (obs !== exp_o) begin
        n_fail++; $display("FAIL lz_basic j=%0d got=%h exp=%h", m_j - 1, obs, exp_o);
      end
      if (anode == 8'hFE && {a, b, c, d, e, f, g} == 7'b0010010) n_fe++;
      else if (anode == 8'hFD && {a, b, c, d, e, f, g} == 7'b1001111) n_fd++;
      else if (anode != 8'hFF) n_other++;
    end
    n_chk++;
    if (n_fe != 16 || n_fd != 16 || n_other != 0) begin
      n_fail++; $display("FAIL lz_counts fe=%0d fd=%0d other=%0d exp 16 16 0", n_fe, n_fd, n_other);
    end
  endtask

  task automatic test_timing();
    int run, last_ft, last_fe;
    logic [7:0] prev;
    align_frame();
    value = 32'h8765_4321; digit_en = 8'hFF; lz_suppress = 1'b0;
    run = 0; last_ft = -1; last_fe = -1; prev = 8'hFF;
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      n_chk++;
      if (obs !== exp_o) begin
        n_fail++; $display("FAIL timing_model j=%0d got=%h exp=%h", m_j - 1, obs, exp_o);
      end
      if (anode != 8'hFF) run++;
      else if (run != 0) begin
        n_chk++;
        if (run != RD - BC) begin
          n_fail++; $display("FAIL low_len got=%0d exp=%0d", run, RD - BC);
        end
        run = 0;
      end
      if (anode == 8'hFE && prev != 8'hFE) begin
        if (last_fe >= 0) begin
          n_chk++;
          if (m_j - last_fe != FR) begin
            n_fail++; $display("FAIL fe_period got=%0d exp=%0d", m_j - last_fe, FR);
          end
        end
        last_fe = m_j;
      end
      if (frame_tick) begin
        if (last_ft >= 0) begin
          n_chk++;
          if (m_j - last_ft != FR) begin
            n_fail++; $display("FAIL tick_period got=%0d exp=%0d", m_j - last_ft, FR);
          end
        end
        last_ft = m_j;
      end
      prev = anode;
    end
  endtask

  task automatic test_midframe();
    logic seen;
    align_frame();
    value = 32'h0000_0012; digit_en = 8'hFF; lz_suppress = 1'b1;
    for (int i = 0; i < FR; i++) begin
      step();
      if (m_j % FR == 35) value = 32'h0000_0099;
      n_chk++;
      if (obs !== exp_o) begin
        n_fail++; $display("FAIL midframe j=%0d got=%h exp=%h", m_j - 1, obs, exp_o);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < RD + 1; i++) begin
      step();
      if (anode == 8'hFE) begin
        seen = 1'b1;
        n_chk++;
        if ({a, b, c, d, e, f, g} !== 7'b0000100) begin
          n_fail++; $display("FAIL next_frame_seg got=%b exp=0000100", {a, b, c, d, e, f, g});
        end
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL next_frame_lit got=0 exp=1");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FR; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        value = $urandom;
        if ($urandom_range(0, 1) == 1) value = value >> (4 * $urandom_range(0, 7));
        digit_en = 8'($urandom); dp_in = 8'($urandom); lz_suppress = 1'($urandom);
      end
      step();
      n_chk++;
      if (obs !== exp_o) begin
        n_fail++; $display("FAIL random j=%0d got=%h exp=%h", m_j - 1, obs, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    logic [7:0] first_lit;
    align_frame();
    value = 32'h1234_5678; digit_en = 8'hFF; lz_suppress = 1'b0; dp_in = 8'h00;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      if ((m_j - 1) % RD == BC + 4 && ((m_j - 1) / RD) % 8 == 3 && (m_j - 1) >= FR) break;
    end
    n_chk++;
    if (anode !== 8'hF7 || obs !== exp_o) begin
      n_fail++; $display("FAIL pre_reset_drive got=%h exp=%h", obs, exp_o);
    end
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if (obs !== DARK) begin
      n_fail++; $display("FAIL async_dark got=%h exp=%h", obs, DARK);
    end
    model_reset();
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    first_lit = 8'hFF;
    for (int i = 0; i < FR; i++) begin
      step();
      n_chk++;
      if (obs !== exp_o) begin
        n_fail++; $display("FAIL after_reset j=%0d got=%h exp=%h", m_j - 1, obs, exp_o);
      end
      if (first_lit == 8'hFF && anode != 8'hFF) first_lit = anode;
    end
    n_chk++;
    if (first_lit !== 8'hFE) begin
      n_fail++; $display("FAIL restart_digit got=%h exp=fe", first_lit);
    end
  endtask

  task automatic test_disabled_dp();
    align_frame();
    value = 32'hFFFF_FFFF; digit_en = 8'h00; dp_in = 8'hFF; lz_suppress = 1'($urandom);
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      n_chk++;
      if (anode !== 8'hFF || obs !== exp_o) begin
        n_fail++; $display("FAIL disabled j=%0d got=%h exp=%h", m_j - 1, obs, exp_o);
      end
    end
    align_frame();
    dp_in = 8'h01; digit_en = 8'h01;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      n_chk++;
      if ((dp === 1'b0) !== (anode === 8'hFE) || obs !== exp_o) begin
        n_fail++; $display("FAIL dp_only_d0 j=%0d got=%h exp=%h", m_j - 1, obs, exp_o);
      end
    end
  endtask

  initial begin
    dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    test_reset();
    test_lz_basic();
    test_timing();
    test_midframe();
    test_random();
    test_reset_mid_drive();
    test_disabled_dp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
